// File: rtl/a5_ctrl_pkg.sv
// Shared constants for the A5/1 session controller: phase lengths, FSM encodings,
// register map, CTRL/STATUS bit positions and the Wishbone request payload.
package a5_ctrl_pkg;

  localparam int unsigned KEY_BITS   = 64;
  localparam int unsigned FRAME_BITS = 22;
  localparam int unsigned MIX_CYCLES = 100;
  localparam int unsigned RUN_BITS   = 228;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned FILL_W  = 5;
  localparam int unsigned STEP_W  = 8;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned IDX_W   = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLEAR = 3'd1;
  localparam logic [STATE_W-1:0] ST_KEY   = 3'd2;
  localparam logic [STATE_W-1:0] ST_FRAME = 3'd3;
  localparam logic [STATE_W-1:0] ST_MIX   = 3'd4;
  localparam logic [STATE_W-1:0] ST_RUN   = 3'd5;

  localparam logic [IDX_W-1:0] REG_DATA   = 3'd0;
  localparam logic [IDX_W-1:0] REG_KEY_LO = 3'd1;
  localparam logic [IDX_W-1:0] REG_KEY_HI = 3'd2;
  localparam logic [IDX_W-1:0] REG_FRAME  = 3'd3;
  localparam logic [IDX_W-1:0] REG_CTRL   = 3'd4;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;

  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_DONE_BIT  = 1;
  localparam int unsigned STAT_EMPTY_BIT = 2;
  localparam int unsigned STAT_FULL_BIT  = 3;

  typedef struct packed {
    logic              we;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        sel;
    logic [WORD_W-1:0] dat;
  } wb_req_t;

  // Replace only the bytes whose select bit is set.
  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_v,
                                                   input logic [WORD_W-1:0] new_v,
                                                   input logic [3:0]        sel);
    logic [WORD_W-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/a5_word_packer.sv
// Collects keystream bits MSB-first into 32-bit words; a finished word is held
// in an output register until the FIFO accepts it, freeing the shifter at once.
module a5_word_packer
  import a5_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic              bit_i,
  input  logic              flush_i,
  input  logic              wr_i,
  output logic              pending_o,
  output logic [WORD_W-1:0] word_o
);

  logic [WORD_W-2:0] sr_q, sr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              pending_q, pending_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              complete;

  assign complete  = shift_i & ((fill_q == FILL_W'(WORD_W - 1)) | flush_i);
  assign pending_o = pending_q;
  assign word_o    = word_q;

  always_comb begin
    sr_d      = sr_q;
    fill_d    = fill_q;
    pending_d = pending_q;
    word_d    = word_q;
    if (clear_i) begin
      sr_d      = '0;
      fill_d    = '0;
      pending_d = 1'b0;
      word_d    = '0;
    end else begin
      if (wr_i) pending_d = 1'b0;
      if (complete) begin
        // Partial final word lands right-aligned because the shifter starts at zero.
        word_d    = {sr_q, bit_i};
        sr_d      = '0;
        fill_d    = '0;
        pending_d = 1'b1;
      end else if (shift_i) begin
        sr_d   = {sr_q[WORD_W-3:0], bit_i};
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      fill_q    <= '0;
      pending_q <= 1'b0;
      word_q    <= '0;
    end else begin
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      pending_q <= pending_d;
      word_q    <= word_d;
    end
  end

endmodule

// File: rtl/a5_session_ctrl.sv
// A5/1 session sequencer: Wishbone register file, clear/load/mix/run phases for
// the external generator, and keystream word hand-off to the external FIFO.
module a5_session_ctrl
  import a5_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        gen_clear,
  output logic        gen_load_en,
  output logic        gen_load_bit,
  output logic        gen_clk_en,
  input  logic        gen_d,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  input  logic        fifo_full,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_rd_data,
  input  logic        fifo_empty
);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [KEY_BITS-1:0]   key_q, key_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
  logic [WORD_W-1:0]     dat_q, dat_d;
  logic                  rd_en_q, rd_en_d;

  wb_req_t           req;
  logic              req_valid, wr_req, rd_req, ctrl_wr;
  logic              busy, start, abort;
  logic              in_run, bits_left, pending, shift, flush;
  logic [WORD_W-1:0] pack_word, frame_w, status_w;
  logic              unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  assign req       = '{we: wbs_we_i, idx: wbs_adr_i[4:2], sel: wbs_sel_i, dat: wbs_dat_i};
  assign req_valid = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign wr_req    = req_valid & req.we;
  assign rd_req    = req_valid & ~req.we;
  assign ctrl_wr   = wr_req & (req.idx == REG_CTRL);
  assign busy      = (state_q != ST_IDLE);
  assign abort     = ctrl_wr & req.dat[CTRL_ABORT_BIT];
  assign start     = ctrl_wr & req.dat[CTRL_START_BIT] & ~req.dat[CTRL_ABORT_BIT] & ~busy;

  // Generator and FIFO strobes decode straight from the phase so a stall takes effect immediately.
  assign in_run       = (state_q == ST_RUN);
  assign bits_left    = (step_q < STEP_W'(RUN_BITS));
  assign gen_clear    = (state_q == ST_CLEAR);
  assign gen_load_en  = (state_q == ST_KEY) | (state_q == ST_FRAME);
  assign gen_load_bit = ((state_q == ST_KEY)   & key_q[step_q[5:0]]) |
                        ((state_q == ST_FRAME) & frame_q[step_q[4:0]]);
  assign gen_clk_en   = (state_q == ST_MIX) |
                        (in_run & bits_left & ~(pending & fifo_full));
  assign shift        = in_run & gen_clk_en;
  assign flush        = shift & (step_q == STEP_W'(RUN_BITS - 1));
  assign fifo_wr_en   = in_run & pending & ~fifo_full & ~abort;
  assign fifo_wr_data = pack_word;
  assign fifo_rd_en   = rd_en_q;
  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;

  a5_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (start | abort),
    .shift_i   (shift),
    .bit_i     (gen_d),
    .flush_i   (flush),
    .wr_i      (fifo_wr_en),
    .pending_o (pending),
    .word_o    (pack_word)
  );

  always_comb begin
    status_w                 = '0;
    status_w[STAT_BUSY_BIT]  = busy;
    status_w[STAT_DONE_BIT]  = done_q;
    status_w[STAT_EMPTY_BIT] = fifo_empty;
    status_w[STAT_FULL_BIT]  = fifo_full;
  end

  // Phase sequencing, then Wishbone-driven overrides.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    done_d  = done_q;
    key_d   = key_q;
    frame_d = frame_q;
    ack_d   = req_valid;
    dat_d   = '0;
    rd_en_d = 1'b0;
    frame_w = byte_merge(WORD_W'(frame_q), req.dat, req.sel);

    case (state_q)
      ST_IDLE: ;
      ST_CLEAR: begin
        state_d = ST_KEY;
        step_d  = '0;
      end
      ST_KEY: begin
        if (step_q == STEP_W'(KEY_BITS - 1)) begin
          state_d = ST_FRAME;
          step_d  = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_FRAME: begin
        if (step_q == STEP_W'(FRAME_BITS - 1)) begin
          state_d = ST_MIX;
          step_d  = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_MIX: begin
        if (step_q == STEP_W'(MIX_CYCLES - 1)) begin
          state_d = ST_RUN;
          step_d  = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_RUN: begin
        if (shift) step_d = step_q + STEP_W'(1);
        if (fifo_wr_en && !bits_left) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d = ST_CLEAR;
      step_d  = '0;
      done_d  = 1'b0;
    end
    if (abort) begin
      state_d = ST_IDLE;
      step_d  = '0;
      done_d  = 1'b0;
    end

    if (wr_req && !busy) begin
      case (req.idx)
        REG_KEY_LO: key_d[31:0]  = byte_merge(key_q[31:0], req.dat, req.sel);
        REG_KEY_HI: key_d[63:32] = byte_merge(key_q[63:32], req.dat, req.sel);
        REG_FRAME:  frame_d      = frame_w[FRAME_BITS-1:0];
        default: ;
      endcase
    end

    if (rd_req) begin
      case (req.idx)
        REG_DATA: begin
          if (!fifo_empty) begin
            dat_d   = fifo_rd_data;
            rd_en_d = 1'b1;
          end
        end
        REG_KEY_LO: dat_d = key_q[31:0];
        REG_KEY_HI: dat_d = key_q[63:32];
        REG_FRAME:  dat_d = WORD_W'(frame_q);
        REG_CTRL:   dat_d = status_w;
        default:    dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      key_q   <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      key_q   <= key_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      rd_en_q <= rd_en_d;
    end
  end

endmodule
